write_buffer: RTL and testbench

Write-through posting buffer between the L1 cache memory port and main memory. Absorbs the cache's write-through stores into a small FIFO and drains them to memory in order. Reads pass straight to memory, or are answered from the buffer when they hit a pending store. Keeps store traffic from stalling the pipeline while guaranteeing read-after-write correctness.

---
 rtl/write_buffer_if.sv | 30 +++
 rtl/write_buffer.sv | 122 ++++++++++++
 tb/tb_write_buffer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/write_buffer_if.sv
// Upstream (L1 memory port) and main-memory handshake signals of the write buffer.
// The two tristate data buses stay plain inout ports on the block.
interface write_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          up_ce;
  logic          up_rw;
  logic [31:0]   up_addr;
  logic          up_stall;
  logic          up_rvalid;
  logic          mem_ce;
  logic          mem_rw;
  logic [31:0]   mem_addr;
  logic          mem_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport slave (
    input  up_ce, up_rw, up_addr, mem_ready,
    output up_stall, up_rvalid, mem_ce, mem_rw, mem_addr, count, full, empty
  );

  modport master (
    output up_ce, up_rw, up_addr, mem_ready,
    input  up_stall, up_rvalid, mem_ce, mem_rw, mem_addr, count, full, empty
  );
endinterface

// File: rtl/write_buffer.sv
// write_buffer: write-through posting FIFO between the L1 memory port and main
// memory. Stores are queued and drained in order; reads go to memory or are
// forwarded from the youngest matching pending store.
module write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  write_buffer_if.slave bus,
  inout  wire [31:0]    up_data,
  inout  wire [31:0]    mem_data
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY, RD_RESP} state_t;
  state_t state_q, state_d;

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [CW-1:0] wr_ptr, rd_ptr, count;
  logic [PW-1:0] wr_idx, rd_idx, idx;
  logic          full, empty, push, pop, is_rd, hit;
  logic [31:0]   hit_data, rd_data, mem_wdata, mem_addr_q;
  logic          mem_ce_q, mem_rw_q;

  assign wr_idx = wr_ptr[PW-1:0];
  assign rd_idx = rd_ptr[PW-1:0];
  assign count  = wr_ptr - rd_ptr;
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign is_rd  = bus.up_ce & bus.up_rw;
  assign push   = bus.up_ce & ~bus.up_rw & ~full;
  assign pop    = (state_q == WR_BUSY) & bus.mem_ready;

  assign bus.up_stall  = bus.up_ce & (bus.up_rw ? (state_q != IDLE) : full);
  assign bus.up_rvalid = (state_q == RD_RESP);
  assign bus.mem_ce    = mem_ce_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.empty     = empty;

  assign up_data  = (state_q == RD_RESP) ? rd_data : 'z;
  assign mem_data = (mem_ce_q && !mem_rw_q) ? mem_wdata : 'z;

  // FIFO pointers; reset discards all buffered entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage, written at the tail on every accepted store
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_idx] <= bus.up_addr;
      data_q[wr_idx] <= up_data;
    end
  end

  // Read-after-write compare: walk oldest to youngest so the youngest match wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_idx + PW'(i);
      if ((CW'(i) < count) && (addr_q[idx][31:2] == bus.up_addr[31:2])) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: reads win in IDLE, otherwise drain the head entry
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (is_rd)       state_d = hit ? RD_RESP : RD_BUSY;
        else if (!empty) state_d = WR_BUSY;
      end
      WR_BUSY: if (bus.mem_ready) state_d = IDLE;
      RD_BUSY: if (bus.mem_ready) state_d = RD_RESP;
      RD_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered memory-side outputs and read data register, loaded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ce_q   <= 1'b0;
      mem_rw_q   <= 1'b1;
      mem_addr_q <= '0;
      mem_wdata  <= '0;
      rd_data    <= '0;
    end else begin
      mem_ce_q <= (state_d == WR_BUSY) || (state_d == RD_BUSY);
      mem_rw_q <= (state_d != WR_BUSY);
      if (state_q == IDLE && state_d == WR_BUSY) begin
        mem_addr_q <= addr_q[rd_idx];
        mem_wdata  <= data_q[rd_idx];
      end
      if (state_q == IDLE && state_d == RD_BUSY) mem_addr_q <= bus.up_addr;
      if (state_q == IDLE && state_d == RD_RESP) rd_data <= hit_data;
      if (state_q == RD_BUSY && bus.mem_ready)   rd_data <= mem_data;
    end
  end
endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer: table-driven store burst plus directed
// sequences for reset, forwarding, read miss, priority and pointer wrap.
module tb_write_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  write_buffer_if #(.DEPTH(4)) bus ();

  wire  [31:0] up_data;
  wire  [31:0] mem_data;
  logic [31:0] up_wdata  = '0;
  logic [31:0] mem_rdata = '0;

  // Released buses read back as all ones
  pullup (up_data);
  pullup (mem_data);

  assign up_data  = (bus.up_ce && !bus.up_rw) ? up_wdata : 'z;
  assign mem_data = (bus.mem_ce && bus.mem_rw) ? mem_rdata : 'z;

  write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .up_data(up_data), .mem_data(mem_data)
  );

  typedef struct packed {logic rw; logic [31:0] a; logic [31:0] d;} acc_t;
  acc_t acc_log[$];
  int unsigned rd_seen = 0;
  logic [2:0]  max_cnt = '0;

  // Memory-side monitor: completed accesses, read activity, peak occupancy
  always @(posedge clk) begin
    if (bus.mem_ce && bus.mem_ready) acc_log.push_back({bus.mem_rw, bus.mem_addr, mem_data});
    if (bus.mem_ce && bus.mem_rw) rd_seen <= rd_seen + 1;
    if (bus.count > max_cnt) max_cnt <= bus.count;
  end

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    int unsigned n = 0;
    bus.up_ce = 1'b1; bus.up_rw = 1'b0; bus.up_addr = a; up_wdata = d;
    #1;
    while (bus.up_stall && n < 50) begin cyc(); n++; end
    if (bus.up_stall) chk("store_timeout", 32'd1, 32'd0);
    cyc();
    bus.up_ce = 1'b0;
  endtask

  // lat = edges from acceptance (inclusive) until up_rvalid is seen
  task automatic rd(input logic [31:0] a, output logic [31:0] d, output int lat);
    logic acc, pre;
    acc = 1'b0; lat = -1; d = '0;
    bus.up_ce = 1'b1; bus.up_rw = 1'b1; bus.up_addr = a;
    #1;
    for (int k = 0; k < 60; k++) begin
      pre = bus.up_stall;
      cyc();
      if (!acc && !pre) begin acc = 1'b1; lat = 0; end
      if (acc) lat++;
      if (bus.up_rvalid) begin d = up_data; break; end
    end
    if (!bus.up_rvalid) lat = -1;
    cyc();
    chk("rvalid_pulse", bus.up_rvalid, 1'b0);
    bus.up_ce = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int unsigned n = 0;
    while (!(bus.empty && !bus.mem_ce) && n < 100) begin cyc(); n++; end
    chk(nm, bus.empty && !bus.mem_ce, 1'b1);
  endtask

  typedef struct {
    logic ce, rw; logic [31:0] addr; logic rdy;
    logic stall; logic [2:0] cnt; logic full, empty, mce, mrw;
  } vec_t;
  vec_t vecs[15];

  initial begin
    logic [31:0] d;
    int lat;
    int unsigned rs0;

    // store burst with memory stalled, 5th store blocked, then drain
    vecs[0]  = '{1'b1,1'b0,32'h100,1'b0, 1'b0,3'd1,1'b0,1'b0,1'b0,1'b1};
    vecs[1]  = '{1'b1,1'b0,32'h104,1'b0, 1'b0,3'd2,1'b0,1'b0,1'b1,1'b0};
    vecs[2]  = '{1'b1,1'b0,32'h108,1'b0, 1'b0,3'd3,1'b0,1'b0,1'b1,1'b0};
    vecs[3]  = '{1'b1,1'b0,32'h10C,1'b0, 1'b0,3'd4,1'b1,1'b0,1'b1,1'b0};
    vecs[4]  = '{1'b1,1'b0,32'h110,1'b0, 1'b1,3'd4,1'b1,1'b0,1'b1,1'b0};
    vecs[5]  = '{1'b1,1'b0,32'h110,1'b1, 1'b1,3'd3,1'b0,1'b0,1'b0,1'b1};
    vecs[6]  = '{1'b1,1'b0,32'h110,1'b0, 1'b0,3'd4,1'b1,1'b0,1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b0,32'h000,1'b1, 1'b0,3'd3,1'b0,1'b0,1'b0,1'b1};
    vecs[8]  = '{1'b0,1'b0,32'h000,1'b1, 1'b0,3'd3,1'b0,1'b0,1'b1,1'b0};
    vecs[9]  = '{1'b0,1'b0,32'h000,1'b1, 1'b0,3'd2,1'b0,1'b0,1'b0,1'b1};
    vecs[10] = '{1'b0,1'b0,32'h000,1'b1, 1'b0,3'd2,1'b0,1'b0,1'b1,1'b0};
    vecs[11] = '{1'b0,1'b0,32'h000,1'b1, 1'b0,3'd1,1'b0,1'b0,1'b0,1'b1};
    vecs[12] = '{1'b0,1'b0,32'h000,1'b1, 1'b0,3'd1,1'b0,1'b0,1'b1,1'b0};
    vecs[13] = '{1'b0,1'b0,32'h000,1'b1, 1'b0,3'd0,1'b0,1'b1,1'b0,1'b1};
    vecs[14] = '{1'b0,1'b0,32'h000,1'b1, 1'b0,3'd0,1'b0,1'b1,1'b0,1'b1};

    bus.up_ce = 1'b0; bus.up_rw = 1'b0; bus.up_addr = '0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", bus.count, 3'd0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_mem_ce", bus.mem_ce, 1'b0);
    chk("rst_mem_rw", bus.mem_rw, 1'b1);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_rvalid", bus.up_rvalid, 1'b0);
    chk("rst_stall", bus.up_stall, 1'b0);
    chk("rst_up_data_z", up_data, 32'hFFFF_FFFF);
    chk("rst_mem_data_z", mem_data, 32'hFFFF_FFFF);
    rst = 1'b0;
    cyc();
    acc_log.delete();

    // table-driven burst
    for (int i = 0; i < 15; i++) begin
      bus.up_ce = vecs[i].ce; bus.up_rw = vecs[i].rw; bus.up_addr = vecs[i].addr;
      up_wdata = {16'hD0D0, vecs[i].addr[15:0]}; bus.mem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_stall", i), bus.up_stall, vecs[i].stall);
      cyc();
      chk($sformatf("v%0d_count", i), bus.count, vecs[i].cnt);
      chk($sformatf("v%0d_full", i), bus.full, vecs[i].full);
      chk($sformatf("v%0d_empty", i), bus.empty, vecs[i].empty);
      chk($sformatf("v%0d_mem_ce", i), bus.mem_ce, vecs[i].mce);
      chk($sformatf("v%0d_mem_rw", i), bus.mem_rw, vecs[i].mrw);
    end
    chk("burst_nwrites", acc_log.size(), 32'd5);
    if (acc_log.size() == 5)
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("burst_w%0d", i), {acc_log[i].rw, acc_log[i].a[30:0]}, {1'b0, 31'h100 + 31'(4 * i)});
        chk($sformatf("burst_d%0d", i), acc_log[i].d, 32'hD0D0_0100 + 32'(4 * i));
      end

    // reset in the middle of a write access with 3 entries held
    bus.mem_ready = 1'b0;
    store(32'h700, 32'h0000_0070);
    store(32'h704, 32'h0000_0074);
    store(32'h708, 32'h0000_0078);
    chk("mid_count", bus.count, 3'd3);
    chk("mid_mem_ce", bus.mem_ce, 1'b1);
    chk("mid_mem_data", mem_data, 32'h0000_0070);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_ce", bus.mem_ce, 1'b0);
    chk("arst_count", bus.count, 3'd0);
    chk("arst_empty", bus.empty, 1'b1);
    chk("arst_up_data_z", up_data, 32'hFFFF_FFFF);
    chk("arst_mem_data_z", mem_data, 32'hFFFF_FFFF);
    cyc();
    rst = 1'b0;
    acc_log.delete();
    bus.mem_ready = 1'b1;
    repeat (6) cyc();
    chk("arst_no_writes", acc_log.size(), 32'd0);

    // forwarding: youngest of two matching entries, no memory read
    bus.mem_ready = 1'b0;
    acc_log.delete();
    rs0 = rd_seen;
    store(32'h500, 32'h0000_0055);
    store(32'h200, 32'hAAAA_0001);
    store(32'h200, 32'hBBBB_0002);
    bus.up_ce = 1'b1; bus.up_rw = 1'b1; bus.up_addr = 32'h200;
    #1;
    chk("fwd_stall_busy", bus.up_stall, 1'b1);
    bus.mem_ready = 1'b1;
    rd(32'h200, d, lat);
    chk("fwd_latency", lat, 32'd1);
    chk("fwd_data", d, 32'hBBBB_0002);
    wait_idle("fwd_drain");
    chk("fwd_no_mem_read", rd_seen - rs0, 32'd0);
    chk("fwd_nwrites", acc_log.size(), 32'd3);
    if (acc_log.size() == 3) chk("fwd_no_coalesce", acc_log[1].d, 32'hAAAA_0001);

    // read miss with memory ready after 3 cycles
    bus.mem_ready = 1'b0;
    mem_rdata = 32'h1234_5678;
    bus.up_ce = 1'b1; bus.up_rw = 1'b1; bus.up_addr = 32'h300;
    #1;
    chk("miss_stall", bus.up_stall, 1'b0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("miss_ce%0d", i), bus.mem_ce, 1'b1);
      chk($sformatf("miss_rw%0d", i), bus.mem_rw, 1'b1);
      chk($sformatf("miss_addr%0d", i), bus.mem_addr, 32'h300);
      chk($sformatf("miss_rv%0d", i), bus.up_rvalid, 1'b0);
      if (i < 2) cyc();
    end
    bus.mem_ready = 1'b1;
    cyc();
    chk("miss_rvalid", bus.up_rvalid, 1'b1);
    chk("miss_data", up_data, 32'h1234_5678);
    chk("miss_ce_low", bus.mem_ce, 1'b0);
    bus.mem_ready = 1'b0;
    cyc();
    chk("miss_rvalid_pulse", bus.up_rvalid, 1'b0);
    chk("miss_up_data_z", up_data, 32'hFFFF_FFFF);
    bus.up_ce = 1'b0;

    // read miss behind a draining store, ahead of the second store
    acc_log.delete();
    store(32'h600, 32'h0000_0001);
    store(32'h604, 32'h0000_0002);
    chk("pri_mem_addr", bus.mem_addr, 32'h600);
    bus.up_ce = 1'b1; bus.up_rw = 1'b1; bus.up_addr = 32'h400;
    #1;
    chk("pri_stall", bus.up_stall, 1'b1);
    cyc();
    chk("pri_stall_hold", bus.up_stall, 1'b1);
    mem_rdata = 32'hCAFE_0400;
    bus.mem_ready = 1'b1;
    rd(32'h400, d, lat);
    chk("pri_latency", lat, 32'd2);
    chk("pri_data", d, 32'hCAFE_0400);
    wait_idle("pri_drain");
    chk("pri_naccess", acc_log.size(), 32'd3);
    if (acc_log.size() == 3) begin
      chk("pri_acc0", acc_log[0], {1'b0, 32'h600, 32'h1});
      chk("pri_acc1", acc_log[1], {1'b1, 32'h400, 32'hCAFE_0400});
      chk("pri_acc2", acc_log[2], {1'b0, 32'h604, 32'h2});
    end

    // wrap-around: 10 stores with memory always ready
    acc_log.delete();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) store(32'h800 + 32'(4 * i), 32'hE000_0000 + 32'(i));
    wait_idle("wrap_drain");
    chk("wrap_nwrites", acc_log.size(), 32'd10);
    if (acc_log.size() == 10)
      for (int i = 0; i < 10; i++)
        chk($sformatf("wrap_acc%0d", i), acc_log[i],
            {1'b0, 32'h800 + 32'(4 * i), 32'hE000_0000 + 32'(i)});
    chk("max_count_le_depth", max_cnt <= 3'd4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
